// File: rtl/draw_pkg.sv
`default_nettype none
// ============================================================================
// Module      : draw_pkg
// Description : Shared definitions for the quad drawing pipeline. Contains the
//               sequencer state encoding, the vertex field indices within a
//               packed quad word {y3,x3,y2,x2,y1,x1,y0,x0} (x0 in the LSBs),
//               and a helper that extracts one field from such a word.
// Ports       : none (package)
// Revision    : 1.0 - initial release
// ============================================================================
package draw_pkg;

  // Sequencer states
  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_LOAD   = 3'd2,
    S_LAUNCH = 3'd3,
    S_WAIT   = 3'd4,
    S_DRAIN  = 3'd5
  } seq_state_t;

  // Field positions inside a packed quad word. Even indices are x, odd are y.
  localparam int X0 = 0;
  localparam int Y0 = 1;
  localparam int X1 = 2;
  localparam int Y1 = 3;
  localparam int X2 = 4;
  localparam int Y2 = 5;
  localparam int X3 = 6;
  localparam int Y3 = 7;

  // Coordinate width assumed by the field helper (matches draw_quad).
  localparam int DRAW_CORDW = 12;

  // Extract field idx (X0..Y3) from a packed quad word.
  function automatic logic [DRAW_CORDW-1:0] vert_field(
    input logic [8*DRAW_CORDW-1:0] word,
    input int                      idx
  );
    return word[idx*DRAW_CORDW +: DRAW_CORDW];
  endfunction

endpackage
`default_nettype wire

// File: rtl/quad_offset.sv
`default_nettype none
// ============================================================================
// Module      : quad_offset
// Description : Combinational displacement of a packed quad word. Every x
//               field gets off_x added and every y field gets off_y added,
//               as plain CORDW-bit two's-complement sums (wrap, no saturation).
// Ports       : quad_word - packed input quad {y3,x3,y2,x2,y1,x1,y0,x0}
//               off_x     - signed x displacement
//               off_y     - signed y displacement
//               verts     - displaced quad, same packing
// Revision    : 1.0 - initial release
// ============================================================================
module quad_offset #(
  parameter int CORDW = 12
) (
  input  logic [8*CORDW-1:0]        quad_word,
  input  logic signed [CORDW-1:0]   off_x,
  input  logic signed [CORDW-1:0]   off_y,
  output logic [8*CORDW-1:0]        verts
);

  for (genvar i = 0; i < 8; i++) begin : g_field
    if ((i % 2) == 0) begin : g_x
      assign verts[i*CORDW +: CORDW] = quad_word[i*CORDW +: CORDW] + off_x;
    end else begin : g_y
      assign verts[i*CORDW +: CORDW] = quad_word[i*CORDW +: CORDW] + off_y;
    end
  end

endmodule
`default_nettype wire

// File: rtl/quad_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : quad_sequencer
// Description : Scene controller that walks a synchronous vertex table, adds
//               a global displacement to each quad and launches draw_quad for
//               each one, waiting for its done. Supports abort with a drain
//               of the rasteriser before returning to idle.
// Ports       : clk, rst              - clock, synchronous active-high reset
//               start, abort          - scene control
//               quad_count            - quads in scene (latched, clamped)
//               off_x, off_y          - displacement (latched at start)
//               tbl_addr / tbl_data   - vertex table port (1-cycle latency)
//               quad_verts            - displaced vertices to draw_quad
//               quad_start            - one-cycle launch pulse
//               quad_busy, quad_done  - draw_quad status
//               quad_id               - index of current quad
//               busy, done            - scene status / completion pulse
// Revision    : 1.0 - initial release
// ============================================================================
module quad_sequencer
  import draw_pkg::*;
#(
  parameter int CORDW = 12,
  parameter int NQUAD = 8,
  parameter int IDW   = $clog2(NQUAD)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      start,
  input  logic                      abort,
  input  logic [IDW:0]              quad_count,
  input  logic signed [CORDW-1:0]   off_x,
  input  logic signed [CORDW-1:0]   off_y,
  output logic [IDW-1:0]            tbl_addr,
  input  logic [8*CORDW-1:0]        tbl_data,
  output logic [8*CORDW-1:0]        quad_verts,
  output logic                      quad_start,
  input  logic                      quad_busy,
  input  logic                      quad_done,
  output logic [IDW-1:0]            quad_id,
  output logic                      busy,
  output logic                      done
);

  localparam logic [IDW:0] C_NQUAD = (IDW+1)'(NQUAD);

  seq_state_t               r_state;
  logic [IDW:0]             r_count;
  logic signed [CORDW-1:0]  r_off_x;
  logic signed [CORDW-1:0]  r_off_y;

  logic [8*CORDW-1:0]       w_verts;
  logic [IDW:0]             w_count_clamped;
  logic                     w_last;

  assign w_count_clamped = (quad_count > C_NQUAD) ? C_NQUAD : quad_count;
  assign w_last          = ({1'b0, quad_id} == (r_count - 1'b1));

  // The table address is the current index itself, so it is registered.
  assign tbl_addr = quad_id;

  quad_offset #(
    .CORDW (CORDW)
  ) u_offset (
    .quad_word (tbl_data),
    .off_x     (r_off_x),
    .off_y     (r_off_y),
    .verts     (w_verts)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_count    <= '0;
      r_off_x    <= '0;
      r_off_y    <= '0;
      quad_verts <= '0;
      quad_start <= 1'b0;
      quad_id    <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
    end else begin
      // Pulses default low; set only on the transition that issues them.
      quad_start <= 1'b0;
      done       <= 1'b0;

      unique case (r_state)
        S_IDLE: begin
          if (start) begin
            r_count <= w_count_clamped;
            r_off_x <= off_x;
            r_off_y <= off_y;
            quad_id <= '0;
            if (w_count_clamped == '0) begin
              // Empty scene completes immediately without launching.
              done <= 1'b1;
            end else begin
              r_state <= S_FETCH;
              busy    <= 1'b1;
            end
          end
        end

        S_FETCH: begin
          if (abort) begin
            r_state <= S_IDLE;
            busy    <= 1'b0;
          end else begin
            r_state <= S_LOAD;
          end
        end

        S_LOAD: begin
          if (abort) begin
            r_state <= S_IDLE;
            busy    <= 1'b0;
          end else begin
            quad_verts <= w_verts;
            quad_start <= 1'b1;
            r_state    <= S_LAUNCH;
          end
        end

        S_LAUNCH: begin
          // The launch pulse is already out, so an abort must drain.
          r_state <= abort ? S_DRAIN : S_WAIT;
        end

        S_WAIT: begin
          if (abort) begin
            r_state <= S_DRAIN;
          end else if (quad_done) begin
            if (w_last) begin
              r_state <= S_IDLE;
              busy    <= 1'b0;
              done    <= 1'b1;
            end else begin
              quad_id <= quad_id + 1'b1;
              r_state <= S_FETCH;
            end
          end
        end

        S_DRAIN: begin
          if (!quad_busy) begin
            r_state <= S_IDLE;
            busy    <= 1'b0;
          end
        end

        default: begin
          r_state <= S_IDLE;
          busy    <= 1'b0;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_quad_sequencer.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_quad_sequencer
// Description : Self-checking bench for quad_sequencer with a synchronous
//               table model, a draw_quad latency model and a launch scoreboard.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_quad_sequencer;
  import draw_pkg::*;

  localparam int CORDW = 12;
  localparam int NQUAD = 8;
  localparam int IDW   = 3;

  logic                     clk = 1'b0;
  logic                     rst = 1'b1;
  logic                     start = 1'b0;
  logic                     abort = 1'b0;
  logic [IDW:0]             quad_count = '0;
  logic signed [CORDW-1:0]  off_x = '0;
  logic signed [CORDW-1:0]  off_y = '0;
  logic [IDW-1:0]           tbl_addr;
  logic [8*CORDW-1:0]       tbl_data;
  logic [8*CORDW-1:0]       quad_verts;
  logic                     quad_start;
  logic                     quad_busy;
  logic                     quad_done;
  logic [IDW-1:0]           quad_id;
  logic                     busy;
  logic                     done;

  always #5 clk = ~clk;

  quad_sequencer #(.CORDW(CORDW), .NQUAD(NQUAD), .IDW(IDW)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .abort      (abort),
    .quad_count (quad_count),
    .off_x      (off_x),
    .off_y      (off_y),
    .tbl_addr   (tbl_addr),
    .tbl_data   (tbl_data),
    .quad_verts (quad_verts),
    .quad_start (quad_start),
    .quad_busy  (quad_busy),
    .quad_done  (quad_done),
    .quad_id    (quad_id),
    .busy       (busy),
    .done       (done)
  );

  // Synchronous vertex table
  logic [8*CORDW-1:0] tbl_mem [NQUAD];
  always @(posedge clk) tbl_data <= tbl_mem[tbl_addr];

  // draw_quad model: busy for lat cycles after a launch, then a done pulse
  int   lat = 40;
  int   cnt = 0;
  logic qd = 1'b0;
  logic qd_inj = 1'b0;
  always @(posedge clk) begin
    qd <= 1'b0;
    if (rst) cnt <= 0;
    else if (quad_start) cnt <= lat;
    else if (cnt != 0) begin
      cnt <= cnt - 1;
      if (cnt == 1) qd <= 1'b1;
    end
  end
  assign quad_busy = (cnt != 0);
  assign quad_done = qd | qd_inj;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int failures = 0;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Scoreboard of expected launches
  typedef struct packed {
    logic [IDW-1:0]     id;
    logic [8*CORDW-1:0] verts;
  } exp_t;
  exp_t exp_q[$];
  exp_t mon_e;
  int   launch_log[$];
  int   qd_log[$];
  int   launches = 0;
  int   dones = 0;
  int   busy_cycles = 0;
  int   done_cyc = 0;

  always @(negedge clk) begin
    if (!rst) begin
      if (busy) busy_cycles++;
      if (qd) qd_log.push_back(cyc);
      if (done) begin dones++; done_cyc = cyc; end
      if (quad_start) begin
        launches++;
        launch_log.push_back(cyc);
        if (exp_q.size() == 0) check("unexpected_launch", 1, 0);
        else begin
          mon_e = exp_q.pop_front();
          check("launch_id", quad_id, mon_e.id);
          check("launch_tbl_addr", tbl_addr, mon_e.id);
          check("launch_verts", quad_verts, mon_e.verts);
        end
      end
    end
  end

  function automatic logic [8*CORDW-1:0] disp(input logic [8*CORDW-1:0] w,
                                              input logic [CORDW-1:0] ox,
                                              input logic [CORDW-1:0] oy);
    logic [8*CORDW-1:0] r;
    r = '0;
    for (int f = 0; f < 8; f++)
      r[f*CORDW +: CORDW] = vert_field(w, f) + (((f % 2) != 0) ? oy : ox);
    return r;
  endfunction

  task automatic push_scene(input int n, input logic [CORDW-1:0] ox, input logic [CORDW-1:0] oy);
    exp_t e;
    for (int i = 0; i < n; i++) begin
      e.id    = IDW'(i);
      e.verts = disp(tbl_mem[i], ox, oy);
      exp_q.push_back(e);
    end
  endtask

  int k_cyc;
  task automatic do_start(input int n, input logic [CORDW-1:0] ox, input logic [CORDW-1:0] oy);
    @(negedge clk);
    quad_count = (IDW+1)'(n);
    off_x = ox;
    off_y = oy;
    start = 1'b1;
    @(posedge clk);
    #1;
    k_cyc = cyc;
    start = 1'b0;
  endtask

  task automatic wait_idle(input string tag, input int budget);
    int n;
    n = 0;
    @(negedge clk);
    while (busy && n < budget) begin @(negedge clk); n++; end
    check(tag, busy, 1'b0);
    repeat (2) @(negedge clk);
  endtask

  task automatic clear_stats();
    launches = 0; dones = 0; busy_cycles = 0;
    launch_log.delete(); qd_log.delete();
  endtask

  int n;
  int hi;
  int lo;
  logic [8*CORDW-1:0] w;

  initial begin
    for (int i = 0; i < NQUAD; i++)
      tbl_mem[i] = {$urandom, $urandom, $urandom};

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check("rst_tbl_addr", tbl_addr, 0);
    check("rst_quad_verts", quad_verts, 0);
    check("rst_quad_start", quad_start, 0);
    check("rst_quad_id", quad_id, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    rst = 1'b0;

    // Happy path: 3 quads, zero offset
    lat = 40;
    clear_stats();
    push_scene(3, 0, 0);
    do_start(3, 0, 0);
    check("happy_busy_rise", busy, 1);
    check("happy_no_early_start", quad_start, 0);
    wait_idle("happy_idle", 400);
    check("happy_launches", launches, 3);
    check("happy_dones", dones, 1);
    check("happy_queue_empty", exp_q.size(), 0);
    check("happy_first_launch", launch_log[0], k_cyc + 2);
    check("happy_overhead_1", launch_log[1], qd_log[0] + 3);
    check("happy_overhead_2", launch_log[2], qd_log[1] + 3);
    check("happy_done_time", done_cyc, qd_log[2] + 1);

    // Displacement and wrap
    lat = 5;
    clear_stats();
    w = tbl_mem[0];
    w[11:0]  = 12'h7F8;   // x0 = 2040
    w[23:12] = 12'hFFB;   // y0 = -5
    tbl_mem[0] = w;
    push_scene(1, 12'sd20, 12'sd10);
    do_start(1, 12'sd20, 12'sd10);
    wait_idle("wrap_idle", 100);
    check("wrap_x0", quad_verts[11:0], 12'h80C);   // -2036
    check("wrap_y0", quad_verts[23:12], 12'h005);
    check("wrap_dones", dones, 1);

    // Count above NQUAD clamps to NQUAD
    lat = 3;
    clear_stats();
    push_scene(NQUAD, 12'sd7, -12'sd3);
    do_start(9, 12'sd7, -12'sd3);
    wait_idle("clamp_idle", 300);
    check("clamp_launches", launches, NQUAD);
    check("clamp_dones", dones, 1);

    // Zero count
    clear_stats();
    do_start(0, 0, 0);
    check("zero_done_pulse", done, 1);
    check("zero_busy", busy, 0);
    repeat (4) @(negedge clk);
    check("zero_busy_cycles", busy_cycles, 0);
    check("zero_launches", launches, 0);
    check("zero_dones", dones, 1);

    // Abort in WAIT during quad 1; draw_quad stays busy 15 more cycles
    lat = 40;
    clear_stats();
    push_scene(2, 12'sd1, 12'sd2);
    do_start(3, 12'sd1, 12'sd2);
    n = 0;
    @(negedge clk);
    while (!(quad_id == 1 && cnt == 16) && n < 300) begin @(negedge clk); n++; end
    check("abort_wait_reached", n < 300, 1);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    hi = 0; lo = 0; n = 0;
    while (busy && n < 100) begin
      if (quad_busy) hi++; else lo++;
      @(negedge clk);
      n++;
    end
    check("abort_drain_busy_cycles", hi, 15);
    check("abort_drain_tail", lo, 1);
    repeat (5) @(negedge clk);
    check("abort_no_done", dones, 0);
    check("abort_launches", launches, 2);
    check("abort_queue_empty", exp_q.size(), 0);

    // Abort colliding with the last done; stray start and quad_done filtered
    lat = 10;
    clear_stats();
    push_scene(2, -12'sd4, 12'sd9);
    do_start(2, -12'sd4, 12'sd9);
    n = 0;
    while (!quad_start && n < 50) begin @(negedge clk); n++; end
    check("coll_launch0_seen", n < 50, 1);
    qd_inj = 1'b1;          // quad_done while in LAUNCH
    quad_count = 4'd8;
    start = 1'b1;           // start while busy
    @(negedge clk);
    qd_inj = 1'b0;
    start = 1'b0;
    n = 0;
    while (!(qd && quad_id == 1) && n < 100) begin @(negedge clk); n++; end
    check("coll_last_done_seen", n < 100, 1);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    wait_idle("coll_idle", 50);
    check("coll_no_done", dones, 0);
    check("coll_launches", launches, 2);
    check("coll_queue_empty", exp_q.size(), 0);

    // Reset mid-scene in LOAD
    lat = 5;
    clear_stats();
    push_scene(3, 0, 0);
    do_start(3, 0, 0);      // now in FETCH
    @(posedge clk);
    @(negedge clk);         // LOAD
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    exp_q.delete();
    check("mrst_tbl_addr", tbl_addr, 0);
    check("mrst_quad_verts", quad_verts, 0);
    check("mrst_quad_start", quad_start, 0);
    check("mrst_quad_id", quad_id, 0);
    check("mrst_busy", busy, 0);
    check("mrst_done", done, 0);
    clear_stats();
    push_scene(1, 12'sd3, 12'sd3);
    do_start(1, 12'sd3, 12'sd3);
    wait_idle("mrst_idle", 100);
    check("mrst_launch_time", launch_log[0], k_cyc + 2);
    check("mrst_launches", launches, 1);
    check("mrst_dones", dones, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
